// File: rtl/axi_lite_read_xbar.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_read_xbar
// Purpose  : One-master, two-slave AXI-lite read router (S0 = CLINT, S1 = memory)
//            with local DECERR generation for unmapped addresses.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_read_xbar #(
    parameter logic [31:0] S0_BASE = 32'h0200_0000,
    parameter logic [31:0] S0_MASK = 32'hFFFF_0000,
    parameter logic [31:0] S1_BASE = 32'h8000_0000,
    parameter logic [31:0] S1_MASK = 32'hF800_0000,
    parameter int          DATA_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    // master side
    input  logic [31:0]       araddr,
    input  logic              arvalid,
    output logic              arready,
    input  logic              rready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    // slave 0 (CLINT)
    output logic [31:0]       s0_araddr,
    output logic              s0_arvalid,
    input  logic              s0_arready,
    output logic              s0_rready,
    input  logic [DATA_W-1:0] s0_rdata,
    input  logic [1:0]        s0_rresp,
    input  logic              s0_rvalid,
    // slave 1 (memory / SoC)
    output logic [31:0]       s1_araddr,
    output logic              s1_arvalid,
    input  logic              s1_arready,
    output logic              s1_rready,
    input  logic [DATA_W-1:0] s1_rdata,
    input  logic [1:0]        s1_rresp,
    input  logic              s1_rvalid,
    // error capture
    output logic              dec_err,
    output logic [31:0]       dec_err_addr
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_WAIT_R = 3'd2,
        ST_ERR    = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    state_t              state_q,        state_d;
    logic [31:0]         addr_q,         addr_d;
    logic                sel_q,          sel_d;
    logic [DATA_W-1:0]   rdata_q,        rdata_d;
    logic [1:0]          rresp_q,        rresp_d;
    logic                rvalid_q,       rvalid_d;
    logic                dec_err_q,      dec_err_d;
    logic [31:0]         dec_err_addr_q, dec_err_addr_d;

    logic                hit0;
    logic                hit1;
    logic                sel_arready;
    logic                sel_rvalid;
    logic [DATA_W-1:0]   sel_rdata;
    logic [1:0]          sel_rresp;

    // S0 wins when both windows match.
    assign hit0 = ((araddr & S0_MASK) == S0_BASE);
    assign hit1 = ((araddr & S1_MASK) == S1_BASE);

    assign sel_arready = sel_q ? s1_arready : s0_arready;
    assign sel_rvalid  = sel_q ? s1_rvalid  : s0_rvalid;
    assign sel_rdata   = sel_q ? s1_rdata   : s0_rdata;
    assign sel_rresp   = sel_q ? s1_rresp   : s0_rresp;

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        sel_d          = sel_q;
        rdata_d        = rdata_q;
        rresp_d        = rresp_q;
        rvalid_d       = rvalid_q;
        dec_err_d      = dec_err_q;
        dec_err_addr_d = dec_err_addr_q;
        s0_arvalid     = 1'b0;
        s1_arvalid     = 1'b0;
        s0_rready      = 1'b0;
        s1_rready      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arvalid) begin
                    addr_d  = araddr;
                    sel_d   = ~hit0;
                    state_d = (hit0 || hit1) ? ST_ADDR : ST_ERR;
                end
            end
            ST_ADDR: begin
                s0_arvalid = ~sel_q;
                s1_arvalid = sel_q;
                if (sel_arready) begin
                    state_d = ST_WAIT_R;
                end
            end
            ST_WAIT_R: begin
                s0_rready = ~sel_q;
                s1_rready = sel_q;
                if (sel_rvalid) begin
                    rdata_d  = sel_rdata;
                    rresp_d  = sel_rresp;
                    rvalid_d = 1'b1;
                    state_d  = ST_RESP;
                end
            end
            ST_ERR: begin
                rdata_d  = '0;
                rresp_d  = 2'b11;
                rvalid_d = 1'b1;
                // Only the first decode error since reset is recorded.
                if (!dec_err_q) begin
                    dec_err_d      = 1'b1;
                    dec_err_addr_d = addr_q;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rready) begin
                    rvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            sel_q          <= 1'b0;
            rdata_q        <= '0;
            rresp_q        <= 2'b00;
            rvalid_q       <= 1'b0;
            dec_err_q      <= 1'b0;
            dec_err_addr_q <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            sel_q          <= sel_d;
            rdata_q        <= rdata_d;
            rresp_q        <= rresp_d;
            rvalid_q       <= rvalid_d;
            dec_err_q      <= dec_err_d;
            dec_err_addr_q <= dec_err_addr_d;
        end
    end

    assign arready      = (state_q == ST_IDLE);
    assign rdata        = rdata_q;
    assign rresp        = rresp_q;
    assign rvalid       = rvalid_q;
    assign s0_araddr    = addr_q;
    assign s1_araddr    = addr_q;
    assign dec_err      = dec_err_q;
    assign dec_err_addr = dec_err_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_read_xbar.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_read_xbar
// Purpose  : Directed plus randomized transaction bench for axi_lite_read_xbar.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_read_xbar;

    localparam logic [31:0] S0_BASE = 32'h0200_0000;
    localparam logic [31:0] S0_MASK = 32'hFFFF_0000;
    localparam logic [31:0] S1_BASE = 32'h8000_0000;
    localparam logic [31:0] S1_MASK = 32'hF800_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic [31:0] s0_araddr, s1_araddr;
    logic        s0_arvalid, s1_arvalid;
    logic        s0_arready, s1_arready;
    logic        s0_rready, s1_rready;
    logic [31:0] s0_rdata, s1_rdata;
    logic [1:0]  s0_rresp, s1_rresp;
    logic        s0_rvalid, s1_rvalid;
    logic        dec_err;
    logic [31:0] dec_err_addr;

    int checks = 0;
    int errors = 0;

    // Reference state for the sticky decode-error capture.
    logic        m_dec;
    logic [31:0] m_dec_addr;

    always #5 clock = ~clock;

    axi_lite_read_xbar dut (
        .clock        (clock),
        .reset        (reset),
        .araddr       (araddr),
        .arvalid      (arvalid),
        .arready      (arready),
        .rready       (rready),
        .rdata        (rdata),
        .rresp        (rresp),
        .rvalid       (rvalid),
        .s0_araddr    (s0_araddr),
        .s0_arvalid   (s0_arvalid),
        .s0_arready   (s0_arready),
        .s0_rready    (s0_rready),
        .s0_rdata     (s0_rdata),
        .s0_rresp     (s0_rresp),
        .s0_rvalid    (s0_rvalid),
        .s1_araddr    (s1_araddr),
        .s1_arvalid   (s1_arvalid),
        .s1_arready   (s1_arready),
        .s1_rready    (s1_rready),
        .s1_rdata     (s1_rdata),
        .s1_rresp     (s1_rresp),
        .s1_rvalid    (s1_rvalid),
        .dec_err      (dec_err),
        .dec_err_addr (dec_err_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // 0 = CLINT, 1 = memory, 2 = unmapped
    function automatic int decode(input logic [31:0] a);
        if ((a & S0_MASK) == S0_BASE) return 0;
        if ((a & S1_MASK) == S1_BASE) return 1;
        return 2;
    endfunction

    task automatic quiet_slaves();
        s0_arready = 1'b0; s0_rvalid = 1'b0; s0_rdata = '0; s0_rresp = '0;
        s1_arready = 1'b0; s1_rvalid = 1'b0; s1_rdata = '0; s1_rresp = '0;
    endtask

    // One complete read. Called with the DUT idle, 1 time unit after a rising edge.
    // d_ar: cycles the slave withholds arready; n_r: cycles from slave AR handshake
    // to slave rvalid; rr_delay: master rvalid cycles seen before raising rready.
    task automatic run_txn(input string tag, input logic [31:0] addr, input int d_ar,
                           input int n_r, input logic [31:0] sdata, input logic [1:0] sresp,
                           input int rr_delay, input bit rr_tied);
        int          tgt;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        int          exp_lat;
        int          ar_hi, hs1, first_rv, rv_cnt, wrong;
        bit          done, r_done, resp_hs;
        tgt = decode(addr);
        if (tgt == 2) begin
            exp_data = '0; exp_resp = 2'b11; exp_lat = 2;
        end else begin
            exp_data = sdata; exp_resp = sresp; exp_lat = 2 + d_ar + n_r;
        end
        ar_hi = 0; hs1 = -1; first_rv = -1; rv_cnt = 0; wrong = 0;
        done = 1'b0; r_done = 1'b0; resp_hs = 1'b0;

        chk({tag, " arready_idle"}, 32'(arready), 32'd1);
        araddr  = addr;
        arvalid = 1'b1;
        rready  = rr_tied;
        @(posedge clock); #1;
        arvalid = 1'b0;
        araddr  = $urandom;

        for (int k = 1; k <= 100 && !done; k++) begin
            logic [1:0] sav, srr;
            logic       sel_ar, sel_rv;
            sav = {s1_arvalid, s0_arvalid};
            srr = {s1_rready, s0_rready};
            sel_ar = 1'b0;
            sel_rv = 1'b0;
            if (tgt == 2) begin
                if (sav != 2'b00 || srr != 2'b00) wrong++;
            end else begin
                if (sav[1-tgt] || srr[1-tgt]) wrong++;
                if (sav[tgt]) begin
                    ar_hi++;
                    chk({tag, " s_araddr"}, (tgt == 0) ? s0_araddr : s1_araddr, addr);
                    if (ar_hi > d_ar && hs1 < 0) begin
                        sel_ar = 1'b1;
                        hs1    = k;
                    end
                end
                if (hs1 >= 0 && k >= hs1 + n_r && !r_done) begin
                    sel_rv = 1'b1;
                    if (srr[tgt]) r_done = 1'b1;
                end
            end
            if (rvalid) begin
                if (first_rv < 0) begin
                    first_rv = k;
                    chk({tag, " latency"}, 32'(k), 32'(exp_lat));
                end
                chk({tag, " rdata"}, rdata, exp_data);
                chk({tag, " rresp"}, 32'(rresp), 32'(exp_resp));
                rv_cnt++;
                if (rr_tied || rv_cnt > rr_delay) begin
                    rready  = 1'b1;
                    resp_hs = 1'b1;
                end else begin
                    rready = 1'b0;
                end
            end else begin
                rready = rr_tied;
            end
            // Unselected slave gets noise every cycle; selected slave follows its script.
            s0_arready = 1'b1 & 1'($urandom); s0_rvalid = 1'($urandom);
            s0_rdata = $urandom; s0_rresp = 2'($urandom);
            s1_arready = 1'($urandom); s1_rvalid = 1'($urandom);
            s1_rdata = $urandom; s1_rresp = 2'($urandom);
            if (tgt == 0) begin
                s0_arready = sel_ar; s0_rvalid = sel_rv;
                s0_rdata = sel_rv ? sdata : $urandom; s0_rresp = sresp;
            end else if (tgt == 1) begin
                s1_arready = sel_ar; s1_rvalid = sel_rv;
                s1_rdata = sel_rv ? sdata : $urandom; s1_rresp = sresp;
            end
            @(posedge clock); #1;
            if (resp_hs) begin
                done = 1'b1;
                chk({tag, " rvalid_after_hs"}, 32'(rvalid), 32'd0);
            end
        end
        quiet_slaves();
        rready = rr_tied;
        chk({tag, " completed"}, 32'(done), 32'd1);
        chk({tag, " wrong_strobes"}, 32'(wrong), 32'd0);
        chk({tag, " s_arvalid_cycles"}, 32'(ar_hi), (tgt == 2) ? 32'd0 : 32'(d_ar + 1));
        chk({tag, " rvalid_cycles"}, 32'(rv_cnt), rr_tied ? 32'd1 : 32'(rr_delay + 1));
        if (tgt == 2 && !m_dec) begin
            m_dec      = 1'b1;
            m_dec_addr = addr;
        end
        chk({tag, " dec_err"}, 32'(dec_err), 32'(m_dec));
        chk({tag, " dec_err_addr"}, dec_err_addr, m_dec_addr);
    endtask

    initial begin
        logic [31:0] a;
        int          cat;
        reset = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b0;
        quiet_slaves();
        m_dec = 1'b0; m_dec_addr = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst arready", 32'(arready), 32'd1);
        chk("rst rvalid", 32'(rvalid), 32'd0);
        chk("rst rresp", 32'(rresp), 32'd0);
        chk("rst rdata", rdata, 32'd0);
        chk("rst s_arvalid", 32'({s1_arvalid, s0_arvalid}), 32'd0);
        chk("rst s_rready", 32'({s1_rready, s0_rready}), 32'd0);
        chk("rst dec_err", 32'(dec_err), 32'd0);
        chk("rst dec_err_addr", dec_err_addr, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        run_txn("clint", 32'h0200_BFF8, 0, 1, 32'h1234_5678, 2'b00, 0, 1'b0);
        run_txn("mem_bp", 32'h8000_0100, 3, 2, 32'hDEAD_BEEF, 2'b00, 4, 1'b0);
        run_txn("unmapped1", 32'h1000_0000, 0, 1, 32'h0, 2'b00, 1, 1'b0);
        run_txn("unmapped2", 32'h2000_0000, 0, 1, 32'h0, 2'b00, 0, 1'b0);
        run_txn("slverr", 32'h8000_0200, 1, 1, 32'hCAFE_F00D, 2'b10, 0, 1'b0);
        run_txn("b2b_s0", 32'h0200_0008, 0, 1, 32'hA5A5_0001, 2'b00, 0, 1'b1);
        run_txn("b2b_s1", 32'h8000_0010, 0, 1, 32'hA5A5_0002, 2'b00, 0, 1'b1);
        rready = 1'b0;

        // Reset while the CLINT read is waiting for data.
        araddr = 32'h0200_0004; arvalid = 1'b1;
        @(posedge clock); #1;
        arvalid = 1'b0;
        chk("rstw s0_arvalid", 32'(s0_arvalid), 32'd1);
        s0_arready = 1'b1;
        @(posedge clock); #1;
        s0_arready = 1'b0;
        chk("rstw s0_rready_pre", 32'(s0_rready), 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        m_dec = 1'b0; m_dec_addr = '0;
        chk("rstw s0_rready", 32'(s0_rready), 32'd0);
        chk("rstw s0_arvalid", 32'(s0_arvalid), 32'd0);
        chk("rstw rvalid", 32'(rvalid), 32'd0);
        chk("rstw arready", 32'(arready), 32'd1);
        chk("rstw dec_err", 32'(dec_err), 32'd0);
        run_txn("post_rst", 32'h0200_0004, 0, 1, 32'h0BAD_C0DE, 2'b00, 0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            cat = int'($urandom_range(0, 2));
            if (cat == 0)      a = S0_BASE | ($urandom & ~S0_MASK);
            else if (cat == 1) a = S1_BASE | ($urandom & ~S1_MASK);
            else               a = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFF);
            run_txn($sformatf("rnd%0d", i), a, int'($urandom_range(0, 3)),
                    int'($urandom_range(1, 3)), $urandom,
                    (($urandom & 1) != 0) ? 2'b10 : 2'b00,
                    int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
